// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the load/store unit and data_mem_ctrl.
// master = load/store unit side, slave = memory controller side.
interface data_mem_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressable RV32 data memory with sized loads/stores, alignment and
// range checking, and a valid/ready request channel of latency LAT.
// A request is accepted in IDLE, waits LAT-1 cycles in WAIT, commits (store
// write / load sample) on the edge entering RESP, and the response strobe is
// registered on the edge leaving RESP.
// Optional macro DMEM_INIT_EN: preloads word0=1, word1=2, word2=3, rest 0.
module data_mem_ctrl #(
   parameter int DEPTH_WORDS = 64,
   parameter int ADDR_W      = 8,
   parameter int LAT         = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   data_mem_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic              rsp_valid_q;
   logic [31:0]       rsp_rdata_q;
   logic              rsp_err_q;

   logic              accept, commit;
   logic              cur_we;
   logic [2:0]        cur_f3;
   logic [ADDR_W-1:0] cur_addr;
   logic [31:0]       cur_wdata;
   logic [ADDR_W-3:0] word_idx;
   logic [IDX_W-1:0]  idx;
   logic [1:0]        lane;
   logic              illegal, misaligned, out_of_range, cur_err;
   logic [31:0]       rword, ld_val, st_data;
   logic [7:0]        bsel;
   logic [15:0]       hsel;
   logic [3:0]        be;

`ifdef DMEM_INIT_EN
   logic [31:0] mem [DEPTH_WORDS] = '{0: 32'd1, 1: 32'd2, 2: 32'd3, default: 32'd0};
`else
   logic [31:0] mem [DEPTH_WORDS];
`endif

   assign bus.req_ready = (state == S_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   assign accept = bus.req_valid && bus.req_ready;
   // With LAT=1 the commit edge is the acceptance edge, so decode straight
   // from the bus while idle and from the captured request afterwards.
   assign commit = (state != S_RESP) && (state_nxt == S_RESP);

   assign cur_we    = (state == S_IDLE) ? bus.req_we     : we_q;
   assign cur_f3    = (state == S_IDLE) ? bus.req_funct3 : f3_q;
   assign cur_addr  = (state == S_IDLE) ? bus.req_addr   : addr_q;
   assign cur_wdata = (state == S_IDLE) ? bus.req_wdata  : wdata_q;

   assign word_idx = cur_addr[ADDR_W-1:2];
   assign idx      = word_idx[IDX_W-1:0];
   assign lane     = cur_addr[1:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.req_valid) state_nxt = (LAT > 1) ? S_WAIT : S_RESP;
         S_WAIT:  if (cnt == CNT_W'(1)) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request capture and latency counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         cnt     <= CNT_W'(LAT - 1);
         we_q    <= bus.req_we;
         f3_q    <= bus.req_funct3;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
      end else if (state == S_WAIT) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Error decode: illegal funct3, misalignment, word index past the array
   always_comb begin
      if (cur_we) illegal = !(cur_f3 inside {3'b000, 3'b001, 3'b010});
      else        illegal = !(cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      case (cur_f3[1:0])
         2'b01:   misaligned = lane[0];
         2'b10:   misaligned = (lane != 2'b00);
         default: misaligned = 1'b0;
      endcase
      out_of_range = (32'(word_idx) >= 32'(DEPTH_WORDS));
      cur_err      = illegal || misaligned || out_of_range;
   end

   // Load extraction with sign/zero extension
   always_comb begin
      rword  = mem[idx];
      bsel   = rword[{lane, 3'b000} +: 8];
      hsel   = lane[1] ? rword[31:16] : rword[15:0];
      ld_val = '0;
      case (cur_f3)
         3'b000:  ld_val = {{24{bsel[7]}}, bsel};
         3'b001:  ld_val = {{16{hsel[15]}}, hsel};
         3'b010:  ld_val = rword;
         3'b100:  ld_val = {24'd0, bsel};
         3'b101:  ld_val = {16'd0, hsel};
         default: ld_val = '0;
      endcase
   end

   // Store byte enables and lane-replicated write data
   always_comb begin
      be      = 4'b0000;
      st_data = cur_wdata;
      case (cur_f3[1:0])
         2'b00: begin
            be      = 4'b0001 << lane;
            st_data = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            be      = lane[1] ? 4'b1100 : 4'b0011;
            st_data = {2{cur_wdata[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   // Array write on the commit edge; contents are never reset
   always_ff @(posedge clk) begin
      if (commit && cur_we && !cur_err) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
   end

   // Commit-time result capture and the one-cycle response strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (commit) begin
            err_q   <= cur_err;
            rdata_q <= (cur_we || cur_err) ? 32'd0 : ld_val;
         end
         if (state == S_RESP) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_q;
            rsp_err_q   <= err_q;
         end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
         end
      end
   end
endmodule
